// File: rtl/l2_req_arbiter.sv
// Arbitrates N L1 back-end masters onto the single L2 request port, holding the grant
// until the L2 completes. Define L2_ARB_RR_EN for round-robin; default is fixed priority.
module l2_req_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic [N_MASTERS-1:0]          gnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic [N_MASTERS-1:0] win_oh;
    logic                 gnt_live;

`ifdef L2_ARB_RR_EN
    localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win_idx;

    // Search starts just after the last winner so every waiter is served within N grants.
    always_comb begin
        // NOTE: every output gets a default before the loops so no path can infer a latch.
        win_oh  = '0;
        win_idx = rr_ptr;
        for (int k = 1; k <= N_MASTERS; k++) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (win_oh == '0 && m_valid[i] && i == (int'(rr_ptr) + k) % N_MASTERS) begin
                    win_oh[i] = 1'b1;
                    win_idx   = PTR_W'(i);
                end
            end
        end
    end
`else
    always_comb begin
        win_oh = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (win_oh == '0 && m_valid[i]) win_oh[i] = 1'b1;
        end
    end
`endif

    // gnt is one-hot (or zero when idle), so an AND-OR mux is enough.
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt[i]) begin
                s_addr  |= m_addr[i*ADDR_W +: ADDR_W];
                s_wdata |= m_wdata[i*DATA_W +: DATA_W];
                s_wstrb |= m_wstrb[i*(DATA_W/8) +: DATA_W/8];
            end
        end
    end

    assign gnt_live = |(gnt & m_valid);
    assign s_valid  = (state == BUSY) && gnt_live;
    assign m_ready  = (state == BUSY) ? (gnt & {N_MASTERS{s_ready}}) : '0;
    assign m_rdata  = {N_MASTERS{s_rdata}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
`ifdef L2_ARB_RR_EN
            rr_ptr <= '0;
`endif
        end else begin
            // NOTE: non-blocking so the muxes above see the pre-edge grant all cycle.
            case (state)
                IDLE: begin
                    if (|m_valid) begin
                        gnt    <= win_oh;
`ifdef L2_ARB_RR_EN
                        rr_ptr <= win_idx;
`endif
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    // Completion or a withdrawn request both end the transaction.
                    if (s_ready || !gnt_live) begin
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
